// File: rtl/sync_fifo_wc.sv
// Single-clock width-converting FIFO; storage and pointers are kept in narrow units.
// Define SYNC_FIFO_WC_ERR_EN to enable the sticky overflow/underflow flags.
module sync_fifo_wc #(
  parameter int DEPTH     = 8,
  parameter int WRWIDTH   = 16,
  parameter int RDWIDTH   = 4,
  parameter int AF_THRESH = DEPTH * ((WRWIDTH > RDWIDTH) ? (WRWIDTH / RDWIDTH) : (RDWIDTH / WRWIDTH))
                          - ((WRWIDTH > RDWIDTH) ? (WRWIDTH / RDWIDTH) : (RDWIDTH / WRWIDTH)),
  parameter int AE_THRESH = (WRWIDTH > RDWIDTH) ? (WRWIDTH / RDWIDTH) : (RDWIDTH / WRWIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_ea,
  input  logic [WRWIDTH-1:0] din,
  input  logic               rd_ea,
  output logic [RDWIDTH-1:0] dout,
  output logic               rd_valid,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [$clog2(DEPTH * ((WRWIDTH > RDWIDTH) ? (WRWIDTH / RDWIDTH) : (RDWIDTH / WRWIDTH))):0] count,
  output logic               overflow,
  output logic               underflow
);
  localparam int NARROW = (WRWIDTH < RDWIDTH) ? WRWIDTH : RDWIDTH;
  localparam int RATIO  = (WRWIDTH > RDWIDTH) ? (WRWIDTH / RDWIDTH) : (RDWIDTH / WRWIDTH);
  localparam int CAP    = DEPTH * RATIO;
  localparam int WU     = WRWIDTH / NARROW;
  localparam int RU     = RDWIDTH / NARROW;
  localparam int AW     = $clog2(CAP);
  localparam int PW     = AW + 1;

  localparam logic [PW-1:0] CAP_L = PW'(CAP);
  localparam logic [PW-1:0] WU_L  = PW'(WU);
  localparam logic [PW-1:0] RU_L  = PW'(RU);
  localparam logic [PW-1:0] AF_L  = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_L  = PW'(AE_THRESH);

  logic [NARROW-1:0]  mem [CAP];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [RDWIDTH-1:0] dout_q, dout_d;
  logic               rd_valid_q, rd_valid_d;
  logic [PW-1:0]      cnt;
  logic [RDWIDTH-1:0] rd_word;
  logic               wr_acc, rd_acc;

  // Pointer difference modulo 2*CAP is the occupancy; the wrap bit keeps full and empty apart.
  assign cnt          = wr_ptr_q - rd_ptr_q;
  assign full         = (CAP_L - cnt) < WU_L;
  assign empty        = cnt < RU_L;
  assign almost_full  = cnt >= AF_L;
  assign almost_empty = cnt <= AE_L;
  assign count        = cnt;
  assign wr_acc       = wr_ea && !full && !rst;
  assign rd_acc       = rd_ea && !empty && !rst;
  assign dout         = dout_q;
  assign rd_valid     = rd_valid_q;

  // Oldest unit lands in the LSBs of the read word.
  genvar gi;
  generate
    for (gi = 0; gi < RU; gi++) begin : g_rd_unit
      assign rd_word[gi*NARROW +: NARROW] = mem[rd_ptr_q[AW-1:0] + AW'(gi)];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < WU; i++) begin
        mem[wr_ptr_q[AW-1:0] + AW'(i)] <= din[i*NARROW +: NARROW];
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    rd_valid_d = 1'b0;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + WU_L;
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + RU_L;
      dout_d     = rd_word;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef SYNC_FIFO_WC_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (wr_ea && full);
    underflow_d = underflow_q | (rd_ea && empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
